// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions for the multiply/divide unit.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package cpu_pkg;

    // Operation select, encoded as funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    // Accept edge to FIX edge for a non-fast-path divide.
    localparam int DIV_LATENCY = 33;

    // Architectural quotient for any division by zero.
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/adder.sv
// Generic W-bit adder/subtractor with carry out.
// Latency: combinational.
// Backpressure: not applicable; carry=1 on subtract means no borrow.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    input  logic         sub_en,
    output logic [W-1:0] sum,
    output logic         carry
);

    // Two's-complement subtract: invert opB and inject the carry-in.
    always_comb begin
        {carry, sum} = {1'b0, opA} + {1'b0, opB ^ {W{sub_en}}} + (W + 1)'(sub_en);
    end

endmodule

// File: rtl/divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Latency: 33 cycles accept-to-FIX; divide-by-zero and signed overflow finish in 1.
// Backpressure: start is accepted only while busy=0; it is dropped, not queued, otherwise.
module divider
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_t;

    div_state_t      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
    logic            neg_q_q, neg_r_q, sel_rem_q;
    logic            busy_q, done_q;

    div_op_t         op_e;
    logic            signed_op, sign_a, sign_b, div_zero, ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;
    logic [XLEN-1:0] rem_shift, trial, rem_d, quo_d;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic            trial_nb;

    // Accept-time decode: operand magnitudes, latched signs and fast-path result.
    always_comb begin
        op_e      = div_op_t'(op);
        signed_op = (op_e == DIV) || (op_e == REM);
        sign_a    = signed_op & dividend[XLEN-1];
        sign_b    = signed_op & divisor[XLEN-1];
        mag_a     = sign_a ? (~dividend + 1'b1) : dividend;
        mag_b     = sign_b ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        ovf       = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                              && (divisor == {XLEN{1'b1}});
        fast_res  = '0;
        if (div_zero) begin
            fast_res = op[1] ? dividend : DIV_BY_ZERO_Q;
        end else begin
            fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Trial subtract of the divisor magnitude from the shifted partial remainder.
    adder #(.W(XLEN)) u_trial (
        .opA    (rem_shift),
        .opB    (dvs_q),
        .sub_en (1'b1),
        .sum    (trial),
        .carry  (trial_nb)
    );

    // One restoring step: keep the difference when it fits, else restore.
    always_comb begin
        rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        if (rem_q[XLEN-1] || trial_nb) begin
            rem_d = trial;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_shift;
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        quo_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Control FSM and datapath registers; flush aborts but never touches result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (div_zero || ovf) begin
                                result_q <= fast_res;
                                done_q   <= 1'b1;
                            end else begin
                                state_q   <= CALC;
                                busy_q    <= 1'b1;
                                cnt_q     <= '0;
                                rem_q     <= '0;
                                quo_q     <= mag_a;
                                dvs_q     <= mag_b;
                                neg_q_q   <= sign_a ^ sign_b;
                                neg_r_q   <= sign_a;
                                sel_rem_q <= op[1];
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        result_q <= sel_rem_q ? rem_fix : quo_fix;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
